pad_out_driver: RTL and testbench
=================================

Name: pad_out_driver

Overview:
- Parametrised, registered output-pad driver for the DM interface; successor to the fixed 4-bit LVCMOS33 output buffer stage.
- Holds a double-buffered level register with a shadow and an atomic UPDATE.
- Adds per-channel one-shot pulse generation of programmable length and per-channel output inversion.
- Sits between control/sequencer logic and the pad OUTBUF instances. PAD_OUT connects 1:1 to OUTBUF D pins.

Parameters:
- WIDTH, 4, number of output channels (1..32).
- PULSE_W, 16, width of the pulse-length field and each per-channel down-counter.
- INV_MASK, {WIDTH{1'b0}}, per-channel output polarity. Bit=1 inverts that channel at the pad.

Ports:
- CLK  in  1  single system clock; all logic is rising-edge.
- RESETN  in  1  synchronous reset, active-low, sampled on CLK rising edge.
- D  in  WIDTH  shadow write data.
- WR  in  1  load D into the shadow register.
- UPDATE  in  1  transfer the shadow register to the level register.
- FIRE  in  1  start pulses on the channels selected by FIRE_MASK.
- FIRE_MASK  in  WIDTH  channel select for FIRE.
- PULSE_LEN  in  PULSE_W  pulse length in CLK cycles, sampled with FIRE.
- PAD_OUT  out  WIDTH  registered pad drive.
- BUSY  out  1  OR of all per-channel pulse-active flags.
- DROPPED  out  1  one-cycle flag: a FIRE hit at least one already-active channel.

Behaviour:
- Clock and reset: one clock (CLK); reset is synchronous and active-low (RESETN). Asserting RESETN=0 at an edge clears state at that edge:
  - shadow=0, level=0, all counters=0, all active flags=0.
  - PAD_OUT=INV_MASK, BUSY=0, DROPPED=0.
  - Reset mid-pulse aborts the pulse immediately. Inputs are ignored while RESETN=0.
- Shadow register: WR=1 at an edge loads shadow<=D. Shadow content is never visible at the pad until UPDATE.
- Level register:
  - UPDATE=1 at an edge loads level<=shadow.
  - If WR=1 and UPDATE=1 in the same cycle, it is write-through: level<=D and shadow<=D.
  - UPDATE with no prior WR reloads the current shadow (no change if already equal).
- Output: PAD_OUT is registered and is computed from next-state values: PAD_OUT <= (level_next ^ active_next) ^ INV_MASK.
  - Latency is 1 cycle: UPDATE or FIRE sampled at edge k is visible on PAD_OUT after edge k.
  - No combinational path from any input to PAD_OUT.
- Pulse, per channel i (independent counters and active flags):
  - Start: at an edge with FIRE=1, FIRE_MASK[i]=1, active_i=0 and PULSE_LEN!=0, set cnt_i<=PULSE_LEN and active_i<=1.
  - While active, the channel drives the inverse of its level.
  - Countdown: each edge with active_i=1 and no new start decrements cnt_i. When cnt_i==1 at an edge, active_i<=0 and cnt_i<=0.
  - Result: the pad is inverted for exactly PULSE_LEN cycles, from edge k to edge k+PULSE_LEN.
  - PULSE_LEN=0: the FIRE is ignored for all channels. No pulse, no DROPPED.
  - FIRE on an active channel: no retrigger and no extension. The counter continues, and DROPPED=1 for the cycle after that edge. Inactive channels in the same mask still start.
  - PULSE_LEN=2^PULSE_W-1: the full count is honoured with no wrap.
- Simultaneous events:
  - UPDATE during an active pulse changes the level. The pad shows the inverse of the new level until the pulse ends, then the new level.
  - FIRE together with UPDATE: both take effect at the same edge.
  - Pulse end coinciding with a new FIRE on the same channel (cnt_i==1 and FIRE): counts as active, so DROPPED=1 and the pulse ends normally.
- BUSY: registered, equal to the OR of active_next. It is 1 exactly while any pulse is in progress.

Test Plan:
- Reset: WIDTH=4, INV_MASK=4'b0010; hold RESETN=0 for 3 cycles with random inputs -> PAD_OUT=4'b0010, BUSY=0, DROPPED=0 throughout and on the first cycle after release.
- Double buffering: WR with D=4'hA, wait 5 cycles -> PAD_OUT=0. Then UPDATE -> PAD_OUT=4'hA the cycle after. Then WR+UPDATE together with D=4'h5 -> PAD_OUT=4'h5 next cycle.
- Pulse length:
  - level=4'h0, FIRE with FIRE_MASK=4'b0100 and PULSE_LEN=3 -> PAD_OUT[2]=1 for exactly 3 cycles, other bits stay 0, BUSY=1 for the same 3 cycles.
  - PULSE_LEN=1 -> a single-cycle pulse.
  - PULSE_LEN=0 -> no change.
- Retrigger: FIRE mask 4'b0001, LEN=10. At cycle 4 of the pulse, FIRE mask 4'b0011, LEN=2 -> ch0 still ends after its 10 cycles, ch1 pulses 2 cycles, DROPPED=1 for exactly one cycle.
- Mid-pulse update:
  - level=4'h0, pulse ch3 with LEN=6, UPDATE to 4'h8 at pulse cycle 2 -> PAD_OUT[3] goes 1,1 then 0 for the remaining 4 cycles, then 1.
  - Separately: RESETN=0 at pulse cycle 3 -> PAD_OUT=INV_MASK and BUSY=0 next cycle.
- Extremes: PULSE_W=4, LEN=15 on all channels -> 15-cycle pulse with no counter wrap. Check WIDTH=1 and WIDTH=32 builds with random WR/UPDATE/FIRE against a reference model.

Source files
------------

// File: rtl/pad_out_driver.sv
// Registered output-pad driver: double-buffered level register plus per-channel
// one-shot pulses of programmable length and per-channel output inversion.
module pad_out_driver #(
  parameter int                WIDTH    = 4,
  parameter int                PULSE_W  = 16,
  parameter logic [WIDTH-1:0]  INV_MASK = {WIDTH{1'b0}}
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic [WIDTH-1:0]    D,
  input  logic                WR,
  input  logic                UPDATE,
  input  logic                FIRE,
  input  logic [WIDTH-1:0]    FIRE_MASK,
  input  logic [PULSE_W-1:0]  PULSE_LEN,
  output logic [WIDTH-1:0]    PAD_OUT,
  output logic                BUSY,
  output logic                DROPPED
);

  localparam logic [PULSE_W-1:0] CNT_ONE = PULSE_W'(1);

  logic [WIDTH-1:0]              shadow_q, shadow_d;
  logic [WIDTH-1:0]              level_q, level_d;
  logic [WIDTH-1:0]              active_q, active_d;
  logic [WIDTH-1:0][PULSE_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]              pad_q, pad_d;
  logic                          busy_q, busy_d;
  logic                          dropped_q, dropped_d;
  logic [WIDTH-1:0]              hit;
  logic                          fire_ok;

  always_comb begin
    shadow_d  = shadow_q;
    level_d   = level_q;
    active_d  = active_q;
    cnt_d     = cnt_q;
    hit       = '0;
    fire_ok   = FIRE && (PULSE_LEN != '0);

    if (WR)
      shadow_d = D;
    // WR together with UPDATE writes straight through to the level register
    if (UPDATE)
      level_d = WR ? D : shadow_q;

    for (int i = 0; i < WIDTH; i++) begin
      if (fire_ok && FIRE_MASK[i] && active_q[i])
        hit[i] = 1'b1;
      if (fire_ok && FIRE_MASK[i] && !active_q[i]) begin
        cnt_d[i]    = PULSE_LEN;
        active_d[i] = 1'b1;
      end else if (active_q[i]) begin
        if (cnt_q[i] == CNT_ONE) begin
          active_d[i] = 1'b0;
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_ONE;
        end
      end
    end

    // Pad and BUSY come from next-state values so FIRE/UPDATE show after one edge
    pad_d     = (level_d ^ active_d) ^ INV_MASK;
    busy_d    = |active_d;
    dropped_d = |hit;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      shadow_q  <= '0;
      level_q   <= '0;
      active_q  <= '0;
      cnt_q     <= '0;
      pad_q     <= INV_MASK;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      level_q   <= level_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      pad_q     <= pad_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

  assign PAD_OUT = pad_q;
  assign BUSY    = busy_q;
  assign DROPPED = dropped_q;

endmodule

// File: tb/tb_pad_out_driver.sv
// Self-checking bench for pad_out_driver: three builds (4/16, 1/4, 32/4) driven
// by shared stimulus and compared against an end-time based reference model.
module tb_pad_out_driver;

  localparam logic [3:0]  INV4  = 4'b0010;
  localparam logic [0:0]  INV1  = 1'b1;
  localparam logic [31:0] INV32 = 32'hA5C3_0F96;
  localparam int W [3] = '{4, 1, 32};
  localparam int P [3] = '{16, 4, 4};

  logic        clk;
  logic        resetn;
  logic [31:0] d;
  logic        wr, upd, fire;
  logic [31:0] fire_mask;
  logic [15:0] pulse_len;

  logic [3:0]  pad4;
  logic        busy4, drop4;
  logic [0:0]  pad1;
  logic        busy1, drop1;
  logic [31:0] pad32;
  logic        busy32, drop32;

  int checks = 0;
  int failures = 0;

  // Reference model state: a pulse is described by the edge number at which it ends
  logic [31:0] inv_v [3];
  logic [31:0] m_shadow [3];
  logic [31:0] m_level [3];
  longint      m_end [3][32];
  longint      t = 0;
  logic [31:0] e_pad [3];
  logic        e_busy [3];
  logic        e_drop [3];

  pad_out_driver #(.WIDTH(4), .PULSE_W(16), .INV_MASK(INV4)) u_dut4 (
    .CLK(clk), .RESETN(resetn), .D(d[3:0]), .WR(wr), .UPDATE(upd), .FIRE(fire),
    .FIRE_MASK(fire_mask[3:0]), .PULSE_LEN(pulse_len), .PAD_OUT(pad4),
    .BUSY(busy4), .DROPPED(drop4));

  pad_out_driver #(.WIDTH(1), .PULSE_W(4), .INV_MASK(INV1)) u_dut1 (
    .CLK(clk), .RESETN(resetn), .D(d[0:0]), .WR(wr), .UPDATE(upd), .FIRE(fire),
    .FIRE_MASK(fire_mask[0:0]), .PULSE_LEN(pulse_len[3:0]), .PAD_OUT(pad1),
    .BUSY(busy1), .DROPPED(drop1));

  pad_out_driver #(.WIDTH(32), .PULSE_W(4), .INV_MASK(INV32)) u_dut32 (
    .CLK(clk), .RESETN(resetn), .D(d), .WR(wr), .UPDATE(upd), .FIRE(fire),
    .FIRE_MASK(fire_mask), .PULSE_LEN(pulse_len[3:0]), .PAD_OUT(pad32),
    .BUSY(busy32), .DROPPED(drop32));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] wmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Advances the model by one rising edge using the rules of the pad driver
  task automatic modelStep(input logic rn, input logic [31:0] dd, input logic w,
                           input logic u, input logic f, input logic [31:0] m,
                           input logic [15:0] l);
    t++;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] msk;
      longint      lenk;
      logic        drop;
      logic [31:0] act;
      msk  = wmask(W[k]);
      lenk = longint'(l) & ((longint'(1) << P[k]) - 1);
      drop = 1'b0;
      act  = '0;
      if (!rn) begin
        m_shadow[k] = '0;
        m_level[k]  = '0;
        for (int ch = 0; ch < 32; ch++) m_end[k][ch] = t;
      end else begin
        if (f && lenk != 0) begin
          for (int ch = 0; ch < W[k]; ch++) begin
            if (m[ch]) begin
              if (m_end[k][ch] >= t) drop = 1'b1;
              else m_end[k][ch] = t + lenk;
            end
          end
        end
        if (u) m_level[k] = (w ? dd : m_shadow[k]) & msk;
        if (w) m_shadow[k] = dd & msk;
      end
      for (int ch = 0; ch < W[k]; ch++)
        if (t < m_end[k][ch]) act[ch] = 1'b1;
      e_pad[k]  = (m_level[k] ^ act ^ inv_v[k]) & msk;
      e_busy[k] = |act;
      e_drop[k] = drop;
    end
  endtask

  // Drives one cycle of inputs, steps the model at the edge, checks every build
  task automatic applyStimulus(input logic rn, input logic [31:0] dd, input logic w,
                               input logic u, input logic f, input logic [31:0] m,
                               input logic [15:0] l);
    resetn = rn; d = dd; wr = w; upd = u; fire = f; fire_mask = m; pulse_len = l;
    @(posedge clk);
    modelStep(rn, dd, w, u, f, m, l);
    @(negedge clk);
    checkOutput("pad4", {28'b0, pad4}, e_pad[0]);
    checkOutput("busy4", {31'b0, busy4}, {31'b0, e_busy[0]});
    checkOutput("drop4", {31'b0, drop4}, {31'b0, e_drop[0]});
    checkOutput("pad1", {31'b0, pad1}, e_pad[1]);
    checkOutput("busy1", {31'b0, busy1}, {31'b0, e_busy[1]});
    checkOutput("drop1", {31'b0, drop1}, {31'b0, e_drop[1]});
    checkOutput("pad32", pad32, e_pad[2]);
    checkOutput("busy32", {31'b0, busy32}, {31'b0, e_busy[2]});
    checkOutput("drop32", {31'b0, drop32}, {31'b0, e_drop[2]});
  endtask

  task automatic idle();
    applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0, $urandom, 16'($urandom));
  endtask

  // Logical level of the 4-bit build with its inversion removed
  function automatic logic [31:0] lvl4();
    return {28'b0, pad4 ^ INV4};
  endfunction

  initial begin
    inv_v[0] = {28'b0, INV4};
    inv_v[1] = {31'b0, INV1};
    inv_v[2] = INV32;
    resetn = 1'b0; d = '0; wr = 1'b0; upd = 1'b0; fire = 1'b0;
    fire_mask = '0; pulse_len = '0;

    // Reset held with random inputs, then release
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom, 16'($urandom));
      checkOutput("rst_pad", {28'b0, pad4}, {28'b0, INV4});
      checkOutput("rst_busy", {31'b0, busy4}, 32'd0);
      checkOutput("rst_drop", {31'b0, drop4}, 32'd0);
    end
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("rel_pad", {28'b0, pad4}, {28'b0, INV4});
    checkOutput("rel_busy", {31'b0, busy4}, 32'd0);

    // Double buffering and write-through
    applyStimulus(1'b1, 32'hA, 1'b1, 1'b0, 1'b0, '0, '0);
    checkOutput("dbuf_wr", lvl4(), 32'h0);
    for (int i = 0; i < 5; i++) begin
      idle();
      checkOutput("dbuf_hold", lvl4(), 32'h0);
    end
    applyStimulus(1'b1, $urandom, 1'b0, 1'b1, 1'b0, '0, '0);
    checkOutput("dbuf_upd", lvl4(), 32'hA);
    applyStimulus(1'b1, 32'h5, 1'b1, 1'b1, 1'b0, '0, '0);
    checkOutput("dbuf_wt", lvl4(), 32'h5);
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, '0, '0);

    // Pulse lengths 3, 1 and 0 on channel 2
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b1, 32'h4, 16'd3);
    checkOutput("len3_c1", lvl4(), 32'h4);
    checkOutput("len3_busy", {31'b0, busy4}, 32'd1);
    idle(); checkOutput("len3_c2", lvl4(), 32'h4);
    idle(); checkOutput("len3_c3", lvl4(), 32'h4);
    checkOutput("len3_busy3", {31'b0, busy4}, 32'd1);
    idle(); checkOutput("len3_end", lvl4(), 32'h0);
    checkOutput("len3_idle", {31'b0, busy4}, 32'd0);
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b1, 32'h4, 16'd1);
    checkOutput("len1_on", lvl4(), 32'h4);
    idle(); checkOutput("len1_off", lvl4(), 32'h0);
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b1, 32'hF, 16'd0);
    checkOutput("len0_pad", lvl4(), 32'h0);
    checkOutput("len0_busy", {31'b0, busy4}, 32'd0);
    checkOutput("len0_drop", {31'b0, drop4}, 32'd0);

    // Retrigger: ch0 runs 10 cycles, ch1 fires at cycle 4 for 2 cycles
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b1, 32'h1, 16'd10);
    idle(); idle();
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b1, 32'h3, 16'd2);
    checkOutput("rtrg_both", lvl4(), 32'h3);
    checkOutput("rtrg_drop", {31'b0, drop4}, 32'd1);
    idle();
    checkOutput("rtrg_drop1", {31'b0, drop4}, 32'd0);
    idle(); checkOutput("rtrg_ch1end", lvl4(), 32'h1);
    for (int i = 0; i < 4; i++) idle();
    checkOutput("rtrg_ch0last", lvl4(), 32'h1);
    idle(); checkOutput("rtrg_ch0end", lvl4(), 32'h0);

    // Mid-pulse UPDATE on ch3
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b1, 32'h8, 16'd6);
    checkOutput("mid_c1", lvl4(), 32'h8);
    idle(); checkOutput("mid_c2", lvl4(), 32'h8);
    applyStimulus(1'b1, '0, 1'b0, 1'b1, 1'b0, '0, '0);
    checkOutput("mid_c3", lvl4(), 32'h0);
    for (int i = 0; i < 3; i++) idle();
    checkOutput("mid_c6", lvl4(), 32'h0);
    idle(); checkOutput("mid_end", lvl4(), 32'h8);

    // Reset at pulse cycle 3 aborts the pulse
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b1, 32'hF, 16'd5);
    checkOutput("rstp_c1", lvl4(), 32'h7);
    idle();
    applyStimulus(1'b0, $urandom, 1'b0, 1'b0, 1'b1, 32'hF, 16'd5);
    checkOutput("rstp_pad", {28'b0, pad4}, {28'b0, INV4});
    checkOutput("rstp_busy", {31'b0, busy4}, 32'd0);
    idle(); checkOutput("rstp_rel", lvl4(), 32'h0);

    // Longest pulse for PULSE_W=4 on every channel
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 16'd15);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) idle();
      checkOutput("max_busy32", {31'b0, busy32}, (j < 15) ? 32'd1 : 32'd0);
      checkOutput("max_pad32", pad32 ^ INV32, (j < 15) ? 32'hFFFF_FFFF : 32'h0);
      checkOutput("max_pad4", lvl4(), (j < 15) ? 32'hF : 32'h0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [15:0] l;
      l = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
      applyStimulus(($urandom_range(0, 59) != 0), $urandom, ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    $urandom, l);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
